// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link constants and master state encoding
package spi_pkg;

  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

  localparam logic SS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - 8-bit reloadable down-counter with terminal-count flag
module spi_half_period_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       tc
);

  logic [7:0] count;

  // A load of N-1 makes tc rise in the Nth cycle after the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign tc = (count == 8'd0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 16-bit SPI master; SPI_MASTER_READBACK_EN builds MISO capture
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int SS_GAP      = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  TX_DATA,
  input  logic [7:0]  TX_ADDRESS,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RX_DATA,
  output logic        SCLK,
  output logic        MOSI,
  output logic        SS,
  input  logic        MISO
);

  localparam logic [7:0] HP_LOAD  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LOAD = 8'(SS_GAP - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  spi_state_t            state;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_tx;
  logic                  load;
  logic [7:0]            load_value;
  logic                  tc;

  spi_half_period_timer u_timer (
    .clk        (CLK),
    .rst        (RST),
    .load       (load),
    .load_value (load_value),
    .tc         (tc)
  );

  always_comb begin
    load       = 1'b0;
    load_value = HP_LOAD;
    case (state)
      IDLE:    load = START;
      HOLD:    begin load = tc; load_value = GAP_LOAD; end
      default: load = tc;
    endcase
  end

`ifdef SPI_MASTER_READBACK_EN
  logic                  miso_meta;
  logic                  miso_sync;
  logic [FRAME_BITS-1:0] shift_rx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = MISO;
  assign RX_DATA     = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shift_tx <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SCLK     <= SCLK_IDLE;
      MOSI     <= 1'b0;
      SS       <= SS_IDLE;
`ifdef SPI_MASTER_READBACK_EN
      shift_rx <= '0;
      RX_DATA  <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          shift_tx <= {TX_DATA, TX_ADDRESS};
          bit_cnt  <= 4'd0;
          BUSY     <= 1'b1;
          SS       <= ~SS_IDLE;
          SCLK     <= SCLK_IDLE;
          MOSI     <= TX_DATA[7];
          state    <= SETUP;
        end
        SETUP, LOW: if (tc) begin
          SCLK  <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (tc) begin
`ifdef SPI_MASTER_READBACK_EN
          shift_rx <= {shift_rx[FRAME_BITS-2:0], miso_sync};
`endif
          SCLK <= SCLK_IDLE;
          if (bit_cnt == LAST_BIT) begin
            state <= HOLD;
          end else begin
            // Rotate rather than shift so the register stays fully used; MOSI
            // changes on the same edge SCLK falls.
            bit_cnt  <= bit_cnt + 4'd1;
            shift_tx <= {shift_tx[FRAME_BITS-2:0], shift_tx[FRAME_BITS-1]};
            MOSI     <= shift_tx[FRAME_BITS-2];
            state    <= LOW;
          end
        end
        HOLD: if (tc) begin
`ifdef SPI_MASTER_READBACK_EN
          RX_DATA <= shift_rx;
`endif
          SS    <= SS_IDLE;
          DONE  <= 1'b1;
          MOSI  <= 1'b0;
          state <= GAP;
        end
        GAP: if (tc) begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized bench for spi_master against a cycle-offset frame model
module tb_spi_master;

  localparam int H          = 4;
  localparam int G          = 4;
  localparam int DONE_K     = 1 + 33 * H;
  localparam int BUSY_END_K = DONE_K + G;
`ifdef SPI_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, START, MISO = 1'b0;
  logic [7:0]  TX_DATA, TX_ADDRESS;
  logic        BUSY, DONE, SCLK, MOSI, SS;
  logic [15:0] RX_DATA;

  logic        start3, miso3 = 1'b0;
  logic [7:0]  tx3d, tx3a;
  logic        busy3, done3, sclk3, mosi3, ss3;
  logic [15:0] rx3;

  always #5 CLK = ~CLK;

  spi_master #(.HALF_PERIOD(H), .SS_GAP(G)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TX_DATA(TX_DATA), .TX_ADDRESS(TX_ADDRESS),
    .BUSY(BUSY), .DONE(DONE), .RX_DATA(RX_DATA), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
  );

  spi_master #(.HALF_PERIOD(3), .SS_GAP(G)) dut3 (
    .CLK(CLK), .RST(RST), .START(start3), .TX_DATA(tx3d), .TX_ADDRESS(tx3a),
    .BUSY(busy3), .DONE(done3), .RX_DATA(rx3), .SCLK(sclk3), .MOSI(mosi3), .SS(ss3), .MISO(miso3)
  );

  int n_pass = 0, n_total = 0, cyc = 0;
  bit t3_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Frame model: m_k counts cycles since the accepted START cycle.
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic [15:0] m_tx = '0, m_miso = '0, m_rx = '0, next_miso;

  always @(posedge CLK) begin
    if (RST) begin
      m_active <= 1'b0;
      m_rx     <= '0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k + 1 == DONE_K)     m_rx <= RB ? m_miso : 16'h0;
      if (m_k + 1 == BUSY_END_K) m_active <= 1'b0;
    end else if (START) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_tx     <= {TX_DATA, TX_ADDRESS};
      m_miso   <= next_miso;
    end
  end

  always @(negedge CLK) begin
    logic e_ss, e_sclk, e_mosi, e_busy, e_done;
    int j;
    if (cyc > 0) begin
      e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (m_active) begin
        e_busy = 1'b1;
        e_done = (m_k == DONE_K);
        if (m_k <= 33 * H) begin
          e_ss = 1'b0;
          j = (m_k - 1) / (2 * H);
          if (j > 15) j = 15;
          e_mosi = m_tx[15 - j];
          e_sclk = (m_k >= 1 + H) && (m_k <= 32 * H) && (((m_k - 1 - H) % (2 * H)) < H);
        end
      end
      chk("ss", SS, e_ss);
      chk("sclk", SCLK, e_sclk);
      chk("mosi", MOSI, e_mosi);
      chk("busy", BUSY, e_busy);
      chk("done", DONE, e_done);
      chk("rx_data", RX_DATA, m_rx);
    end
  end

  // Pin watcher: slave receiver, MISO source, DONE bookkeeping.
  logic        sclk_q = 1'b0, ss_q = 1'b1;
  int          rise_idx = 0, sl_cnt = 0, sl_bits = 0, done_cnt = 0, done_cyc = 0, ss_sclk_viol = 0;
  logic [15:0] sl_sh = '0, sl_word = '0;

  always @(negedge CLK) begin
    sclk_q <= SCLK;
    ss_q   <= SS;
    if (SS) rise_idx <= 0;
    else if (SCLK && !sclk_q) begin
      MISO     <= m_miso[15 - rise_idx];
      rise_idx <= rise_idx + 1;
      sl_sh    <= {sl_sh[14:0], MOSI};
      sl_cnt   <= sl_cnt + 1;
    end
    if (!SS && ss_q) begin sl_sh <= '0; sl_cnt <= 0; end
    if (SS && !ss_q) begin sl_word <= sl_sh; sl_bits <= sl_cnt; end
    if (SS && SCLK) ss_sclk_viol <= ss_sclk_viol + 1;
    if (DONE) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
  end

  logic        sclk3_q = 1'b0, ss3_q = 1'b1;
  logic [15:0] sl3_sh = '0, sl3_word = '0;

  always @(negedge CLK) begin
    sclk3_q <= sclk3;
    ss3_q   <= ss3;
    if (!ss3 && sclk3 && !sclk3_q) sl3_sh <= {sl3_sh[14:0], mosi3};
    if (ss3 && !ss3_q) sl3_word <= sl3_sh;
  end

  task automatic launch(input logic [7:0] d, input logic [7:0] a, input logic [15:0] mw, output int acc);
    START = 1'b1; TX_DATA = d; TX_ADDRESS = a; next_miso = mw;
    acc = cyc;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge CLK); n++; end
    chk("done_within_budget", done_cnt != d0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 400) begin @(negedge CLK); n++; end
    chk("busy_clears_within_budget", BUSY, 0);
  endtask

  task automatic step();
    @(negedge CLK);
    TX_DATA = 8'($urandom); TX_ADDRESS = 8'($urandom); next_miso = 16'($urandom);
  endtask

  initial begin : stim
    int acc, d0, n;
    logic [15:0] w;
    RST = 1'b1; START = 1'b0; TX_DATA = '0; TX_ADDRESS = '0; next_miso = '0;
    repeat (3) @(negedge CLK);
    chk("reset_ss", SS, 1); chk("reset_sclk", SCLK, 0); chk("reset_busy", BUSY, 0);
    chk("reset_rx", RX_DATA, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Write frame with readback and an ignored START at cycle 50
    d0 = done_cnt;
    launch(8'hA5, 8'h3C, 16'h5AC3, acc);
    while (cyc < acc + 50) @(negedge CLK);
    START = 1'b1; TX_DATA = 8'hFF; TX_ADDRESS = 8'hFF;
    @(negedge CLK);
    START = 1'b0;
    wait_done(d0, 300);
    chk("t1_done_cycle", done_cyc - acc, 133);
    chk("t1_rx_data", RX_DATA, RB ? 16'h5AC3 : 16'h0000);
    wait_idle();
    chk("t1_busy_low_cycle", cyc - acc, 137);
    chk("t1_slave_word", sl_word, 16'hA53C);
    chk("t1_slave_bits", sl_bits, 16);
    repeat (10) @(negedge CLK);
    chk("t1_single_done", done_cnt - d0, 1);

    // Back-to-back with START held high
    START = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (!SS && n < 400) begin step(); n++; end
      n = 0;
      while (SS && n < 50) begin step(); n++; end
      chk("b2b_ss_high_cycles", n, f == 0 ? n : G + 1);
    end
    START = 1'b0;
    wait_idle();
    chk("b2b_sclk_quiet_while_ss_high", ss_sclk_viol, 0);

    // Mid-frame reset then a clean frame
    w = 16'($urandom);
    launch(w[15:8], w[7:0], 16'($urandom), acc);
    while (cyc < acc + 60) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_ss", SS, 1); chk("rst_sclk", SCLK, 0); chk("rst_mosi", MOSI, 0);
    chk("rst_busy", BUSY, 0); chk("rst_rx", RX_DATA, 0);
    d0 = done_cnt;
    repeat (200) @(negedge CLK);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_short_frame", sl_bits < 16, 1);
    w = 16'($urandom);
    launch(w[15:8], w[7:0], 16'($urandom), acc);
    wait_done(d0, 300);
    wait_idle();
    chk("rst_clean_frame", sl_word, w);
    chk("rst_clean_bits", sl_bits, 16);

    // Random frames with spurious STARTs while busy
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      d0 = done_cnt;
      launch(w[15:8], w[7:0], 16'($urandom), acc);
      n = 0;
      while (done_cnt == d0 && n < 300) begin
        step();
        START = ($urandom_range(0, 7) == 0);
        n++;
      end
      START = 1'b0;
      chk("rand_done_seen", done_cnt - d0, 1);
      wait_idle();
      chk("rand_slave_word", sl_word, w);
      repeat ($urandom_range(0, 5)) @(negedge CLK);
    end

    chk("hp3_finished", t3_done, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : hp3
    int acc3, n;
    start3 = 1'b0; tx3d = '0; tx3a = '0;
    repeat (5) @(negedge CLK);
    start3 = 1'b1; tx3d = 8'hA5; tx3a = 8'h3C;
    acc3 = cyc;
    @(negedge CLK);
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 200) begin @(negedge CLK); n++; end
    chk("hp3_done_cycle", cyc - acc3, 100);
    chk("hp3_busy_in_gap", busy3, 1);
    chk("hp3_rx_zero_miso", rx3, 0);
    @(negedge CLK);
    chk("hp3_slave_word", sl3_word, 16'hA53C);
    t3_done = 1'b1;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

endmodule
